datactrl: RTL and testbench
===========================

# datactrl

Memory-side data controller for the out-of-order core. It sits directly downstream of the load buffer and the reorder buffer's store-commit path. It serialises their word, halfword and byte accesses onto the 8-bit synchronous RAM port, assembling load results and returning them with sign or zero extension. Stores are committed and therefore have priority; loads are speculative and are abortable by a ROB flush.

## Interface
Parameters:
- None. Widths come from `constant.vh`: `AddressWidth` = 32, `IDWidth` = 32.

Ports (name, direction, width, meaning):
- clk_in  in  1  clock; single clock domain.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- lbuffer_datactrl_en_in  in  1  load request, level-held until done.
- lbuffer_datactrl_addr_in  in  AddressWidth  load byte address.
- lbuffer_datactrl_width_in  in  3  byte count: 3'b001, 3'b010 or 3'b100.
- lbuffer_datactrl_sgn_in  in  1  sign-extend load result.
- datactrl_lbuffer_en_out  out  1  one-cycle load-done pulse.
- datactrl_lbuffer_data_out  out  IDWidth  load result, valid with the done pulse.
- rob_datactrl_en_in  in  1  store request, level-held until done.
- rob_datactrl_addr_in  in  AddressWidth  store byte address.
- rob_datactrl_width_in  in  3  byte count, same encoding as loads.
- rob_datactrl_data_in  in  IDWidth  store data; the low bytes are used.
- datactrl_rob_en_out  out  1  one-cycle store-done pulse.
- rob_datactrl_rst_in  in  1  misprediction flush.
- mem_a_out  out  AddressWidth  RAM address, registered.
- mem_dout_out  out  8  RAM write byte, registered.
- mem_wr_out  out  1  RAM write strobe, registered.
- mem_din_in  in  8  RAM read byte.

## Operation
- States: IDLE, LOAD, STORE.
- Registers: byte counter `cnt[2:0]`, base address, width, sgn, store data, 32-bit assembly register.
- **Reset (rst_in low):** asynchronous. State = IDLE, cnt = 0. Every output is 0, including mem_a_out, mem_dout_out, mem_wr_out, both done pulses and data_out.
- **IDLE → STORE:** rob_datactrl_en_in high and both done outputs low. Latch the request. Stores have priority over loads.
- **IDLE → LOAD:** lbuffer_datactrl_en_in high, no store request, both done outputs low, and rob_datactrl_rst_in low.
- **The "done outputs low" rule** forces a one-cycle bubble after each completion. This bubble lets the requester drop its level-held enable before it can be re-accepted.
- **STORE:**
  - Per edge, byte k = 0..N-1: mem_a_out = base+k, mem_dout_out = data[8k+7:8k], mem_wr_out = 1.
  - At the edge after the last byte: mem_wr_out = 0, datactrl_rob_en_out = 1, state → IDLE.
- **LOAD:**
  - mem_a_out = base+k is issued on consecutive edges for k = 0..N-1.
  - The byte for the address registered at edge t is on mem_din_in and is sampled at edge t+2.
  - Byte k is placed at bits [8k+7:8k].
  - After byte N-1 is sampled, data_out is driven with the result and datactrl_lbuffer_en_out = 1, state → IDLE.
- **Load extension:**
  - sgn=1: bits above 8N are a copy of bit 8N-1.
  - sgn=0: bits above 8N are zero.
  - Width 4 ignores sgn.
- **Address arithmetic:** base+k is modulo 2^32; 0xFFFFFFFF+1 wraps to 0. No alignment is required.
- **Flush (rob_datactrl_rst_in):**
  - In LOAD: state → IDLE, no done pulse, cnt = 0.
  - In STORE: ignored; the committed store completes.
  - In IDLE: suppresses load acceptance only.
- **rdy_in low:** state, counters and all registered outputs hold. Done pulses are stretched until rdy_in returns, then last one more cycle.
- Unsupported widths (e.g. 3'b000) are treated as 1 byte.

## Timing
- Store latency: accept edge E0, bytes written at edges E0..E(N-1), done high during the cycle after E(N).
  - N=4: done is visible 4 cycles after accept.
- Load latency: accept edge E0, addresses at E0..E(N-1), last byte sampled at E(N+1), done high during the cycle after E(N+1).
  - N=4: 5 cycles. N=1: 2 cycles.
- Done pulses last exactly one cycle while rdy_in is high.
- Minimum gap between completion and the next accept: 1 cycle.
- mem_wr_out is never high in LOAD or IDLE.

## Structure
- `constant.vh` holds `AddressWidth`, `IDWidth`, and the width codes `WidthB`/`WidthH`/`WidthW` (3'b001/3'b010/3'b100).
- State encodings are localparams in the module.
- The design is a single flat module; there is no natural sub-module. The extension logic is a small always block.

## Test plan
- **LW:** RAM 0x100..0x103 = 11,22,33,44, LW 0x100. Expect data 0x44332211 with done 5 cycles after accept and mem_wr_out always 0.
- **Extension:** byte 0x80 at 0x10.
  - LB 0x10 → 0xFFFFFF80.
  - LBU 0x10 → 0x00000080.
  - LH of bytes 01,80 → 0xFFFF8001.
  - LHU of the same bytes → 0x00008001.
- **Priority:** load and store requests rise together, SW 0xDEADBEEF @0x200. Expect writes EF,BE,AD,DE to 0x200..0x203, store done, a one-cycle bubble, then the load is served. Reading back 0x200 gives 0xDEADBEEF.
- **Flush:**
  - Flush at cycle 2 of a load → no load-done pulse; the next load returns correct data.
  - Flush during SH 0xABCD → both bytes are written and store done is asserted.
- **rdy_in stall:** rdy_in low for 3 cycles mid-LW → same result, latency 8 cycles.
- **Reset and wrap:**
  - rst_in low mid-store → all outputs 0 immediately, before the next clock edge; after release the block is IDLE.
  - LH at 0xFFFFFFFF reads bytes from 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/datactrl_pkg.sv
// Shared widths, access-size codes and helpers for the memory-side data controller.
package datactrl_pkg;
  localparam int AddressWidth = 32;
  localparam int IDWidth      = 32;

  localparam logic [2:0] WidthB = 3'b001;
  localparam logic [2:0] WidthH = 3'b010;
  localparam logic [2:0] WidthW = 3'b100;

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  // Unsupported size codes fall back to a single byte.
  function automatic logic [2:0] byte_count(input logic [2:0] w);
    case (w)
      WidthB:  return 3'd1;
      WidthH:  return 3'd2;
      WidthW:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [IDWidth-1:0] extend(input logic [IDWidth-1:0] v,
                                                input logic [2:0] n, input logic sgn);
    case (n)
      3'd1:    return {{24{sgn & v[7]}}, v[7:0]};
      3'd2:    return {{16{sgn & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction
endpackage

// File: rtl/datactrl.sv
// Serialises committed stores and speculative loads onto an 8-bit synchronous RAM port,
// assembling and extending load results.
module datactrl
  import datactrl_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    lbuffer_datactrl_en_in,
  input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]              lbuffer_datactrl_width_in,
  input  logic                    lbuffer_datactrl_sgn_in,
  output logic                    datactrl_lbuffer_en_out,
  output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
  input  logic                    rob_datactrl_en_in,
  input  logic [AddressWidth-1:0] rob_datactrl_addr_in,
  input  logic [2:0]              rob_datactrl_width_in,
  input  logic [IDWidth-1:0]      rob_datactrl_data_in,
  output logic                    datactrl_rob_en_out,
  input  logic                    rob_datactrl_rst_in,
  output logic [AddressWidth-1:0] mem_a_out,
  output logic [7:0]              mem_dout_out,
  output logic                    mem_wr_out,
  input  logic [7:0]              mem_din_in
);

  state_t                  state;
  logic [2:0]              cnt, rcv, nb, got;
  logic [AddressWidth-1:0] base;
  logic                    sgn;
  logic [IDWidth-1:0]      sdata, asm_q, asm_nx;
  logic [1:0]              vld_pipe;
  logic [1:0][1:0]         idx_pipe;
  logic                    done_any, st_acc, ld_acc, issue;
  logic [1:0]              issue_idx;

  assign done_any  = datactrl_lbuffer_en_out | datactrl_rob_en_out;
  assign st_acc    = rdy_in && state == IDLE && rob_datactrl_en_in && !done_any;
  assign ld_acc    = rdy_in && state == IDLE && lbuffer_datactrl_en_in && !rob_datactrl_en_in
                     && !done_any && !rob_datactrl_rst_in;
  assign issue     = ld_acc || (rdy_in && state == LOAD && !rob_datactrl_rst_in && cnt < nb);
  assign issue_idx = ld_acc ? 2'd0 : cnt[1:0];
  assign got       = rcv + {2'b00, vld_pipe[1]};

  always_comb begin
    asm_nx = asm_q;
    if (vld_pipe[1]) asm_nx[{idx_pipe[1], 3'b000} +: 8] = mem_din_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                     <= IDLE;
      cnt                       <= '0;
      rcv                       <= '0;
      nb                        <= 3'd1;
      base                      <= '0;
      sgn                       <= 1'b0;
      sdata                     <= '0;
      asm_q                     <= '0;
      vld_pipe                  <= '0;
      idx_pipe                  <= '0;
      mem_a_out                 <= '0;
      mem_dout_out              <= '0;
      mem_wr_out                <= 1'b0;
      datactrl_lbuffer_en_out   <= 1'b0;
      datactrl_lbuffer_data_out <= '0;
      datactrl_rob_en_out       <= 1'b0;
    end else begin
      // The RAM keeps returning data while rdy_in is low, so read returns are
      // tracked and captured every cycle; everything else waits for rdy_in.
      vld_pipe <= {vld_pipe[0], issue};
      idx_pipe <= {idx_pipe[0], issue_idx};
      if (vld_pipe[1]) begin
        asm_q <= asm_nx;
        rcv   <= got;
      end
      if (rdy_in) begin
        datactrl_lbuffer_en_out <= 1'b0;
        datactrl_rob_en_out     <= 1'b0;
        case (state)
          IDLE: begin
            if (st_acc) begin
              state        <= STORE;
              base         <= rob_datactrl_addr_in;
              nb           <= byte_count(rob_datactrl_width_in);
              sdata        <= rob_datactrl_data_in;
              mem_a_out    <= rob_datactrl_addr_in;
              mem_dout_out <= rob_datactrl_data_in[7:0];
              mem_wr_out   <= 1'b1;
              cnt          <= 3'd1;
            end else if (ld_acc) begin
              state     <= LOAD;
              base      <= lbuffer_datactrl_addr_in;
              nb        <= byte_count(lbuffer_datactrl_width_in);
              sgn       <= lbuffer_datactrl_sgn_in;
              mem_a_out <= lbuffer_datactrl_addr_in;
              cnt       <= 3'd1;
              rcv       <= '0;
              asm_q     <= '0;
            end
          end
          LOAD: begin
            if (rob_datactrl_rst_in) begin
              state    <= IDLE;
              cnt      <= '0;
              rcv      <= '0;
              vld_pipe <= '0;
            end else begin
              if (cnt < nb) begin
                mem_a_out <= base + AddressWidth'(cnt);
                cnt       <= cnt + 3'd1;
              end
              if (got == nb) begin
                datactrl_lbuffer_data_out <= extend(asm_nx, nb, sgn);
                datactrl_lbuffer_en_out   <= 1'b1;
                state                     <= IDLE;
                cnt                       <= '0;
              end
            end
          end
          STORE: begin
            if (cnt < nb) begin
              mem_a_out    <= base + AddressWidth'(cnt);
              mem_dout_out <= sdata[{cnt[1:0], 3'b000} +: 8];
              cnt          <= cnt + 3'd1;
            end else begin
              mem_wr_out          <= 1'b0;
              datactrl_rob_en_out <= 1'b1;
              state               <= IDLE;
              cnt                 <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_datactrl.sv
// Directed and random checks of datactrl against a byte-array memory model.
module tb_datactrl;
  logic        clk, rst_n, rdy, flush;
  logic        lb_en, lb_sgn, lb_done, rob_en, rob_done, mem_wr;
  logic [31:0] lb_addr, lb_data, rob_addr, rob_data, mem_a;
  logic [2:0]  lb_width, rob_width;
  logic [7:0]  mem_dout, mem_din;

  logic [7:0]  ram     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        ram_clr, pre_we;
  logic [9:0]  pre_a;
  logic [7:0]  pre_d;

  int vectors = 0;
  int miscompares = 0;

  datactrl dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .lbuffer_datactrl_en_in(lb_en), .lbuffer_datactrl_addr_in(lb_addr),
    .lbuffer_datactrl_width_in(lb_width), .lbuffer_datactrl_sgn_in(lb_sgn),
    .datactrl_lbuffer_en_out(lb_done), .datactrl_lbuffer_data_out(lb_data),
    .rob_datactrl_en_in(rob_en), .rob_datactrl_addr_in(rob_addr),
    .rob_datactrl_width_in(rob_width), .rob_datactrl_data_in(rob_data),
    .datactrl_rob_en_out(rob_done), .rob_datactrl_rst_in(flush),
    .mem_a_out(mem_a), .mem_dout_out(mem_dout), .mem_wr_out(mem_wr), .mem_din_in(mem_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: address registered by the DUT at edge t is read at t+1.
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    else if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  function automatic int nbytes(input logic [2:0] w);
    return (w == 3'd2) ? 2 : (w == 3'd4) ? 4 : 1;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] w, input logic s);
    int n;
    logic [31:0] v, p;
    n = nbytes(w);
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      p = a + 32'(k);
      v = v | (32'(ref_mem[p[9:0]]) << (8 * k));
    end
    if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_lb_done"}, 32'(lb_done), 32'd0);
    chk({tag, "_rob_done"}, 32'(rob_done), 32'd0);
    chk({tag, "_lb_data"}, lb_data, 32'd0);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pre_a = a[9:0];
    pre_d = d;
    pre_we = 1'b1;
    ref_mem[a[9:0]] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] w, input logic s,
                         input int stall_at, input int flush_at, output logic [31:0] got);
    int cyc, lim, n;
    bit done;
    logic [31:0] exp;
    n = nbytes(w);
    exp = exp_load(a, w, s);
    lim = (flush_at > 0) ? 12 : 40;
    lb_addr = a; lb_width = w; lb_sgn = s; lb_en = 1'b1;
    cyc = 0; done = 0; got = '0;
    while (!done && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (cyc == flush_at) begin flush = 1'b1; lb_en = 1'b0; end
      if (flush_at > 0 && cyc == flush_at + 1) flush = 1'b0;
      if (cyc == stall_at) rdy = 1'b0;
      if (stall_at > 0 && cyc == stall_at + 3) rdy = 1'b1;
      chk("load_no_write", 32'(mem_wr), 32'd0);
      if (lb_done) begin done = 1; got = lb_data; end
    end
    lb_en = 1'b0; flush = 1'b0; rdy = 1'b1;
    if (flush_at > 0) chk("flush_no_done", 32'(done), 32'd0);
    else begin
      chk("load_done", 32'(done), 32'd1);
      chk("load_data", got, exp);
      if (stall_at == 0 || n > 1)
        chk("load_latency", cyc - 1, n + 1 + ((stall_at > 0) ? 3 : 0));
    end
    @(negedge clk);
    chk("load_pulse_one_cycle", 32'(lb_done), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d,
                          input int flush_at);
    int cyc, n, nw;
    bit done;
    logic [31:0] sh, pa;
    n = nbytes(w);
    rob_addr = a; rob_width = w; rob_data = d; rob_en = 1'b1;
    cyc = 0; nw = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == flush_at) flush = 1'b1;
      if (flush_at > 0 && cyc == flush_at + 1) flush = 1'b0;
      if (mem_wr) begin
        sh = d >> (8 * nw);
        chk("store_addr", mem_a, a + 32'(nw));
        chk("store_byte", 32'(mem_dout), 32'(sh[7:0]));
        nw++;
      end
      if (rob_done) done = 1;
    end
    rob_en = 1'b0; flush = 1'b0;
    chk("store_done", 32'(done), 32'd1);
    chk("store_nbytes", nw, n);
    chk("store_latency", cyc - 1, n);
    for (int k = 0; k < n; k++) begin
      pa = a + 32'(k);
      sh = d >> (8 * k);
      ref_mem[pa[9:0]] = sh[7:0];
    end
    @(negedge clk);
    chk("store_pulse_one_cycle", 32'(rob_done), 32'd0);
  endtask

  initial begin
    int cyc, st_cyc, ld_cyc, nw;
    logic [31:0] v, sh;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; lb_en = 1'b0; rob_en = 1'b0;
    lb_addr = '0; lb_width = 3'd1; lb_sgn = 1'b0;
    rob_addr = '0; rob_width = 3'd1; rob_data = '0;
    ram_clr = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    #3 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    ram_clr = 1'b0; rst_n = 1'b1;

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h10, 8'h80); poke(32'h20, 8'h01); poke(32'h21, 8'h80);
    poke(32'hFFFF_FFFF, 8'h7F); poke(32'h0, 8'h9A);

    do_load(32'h100, 3'b100, 1'b0, 0, 0, v); chk("lw", v, 32'h4433_2211);
    do_load(32'h10, 3'b001, 1'b1, 0, 0, v);  chk("lb", v, 32'hFFFF_FF80);
    do_load(32'h10, 3'b001, 1'b0, 0, 0, v);  chk("lbu", v, 32'h0000_0080);
    do_load(32'h20, 3'b010, 1'b1, 0, 0, v);  chk("lh", v, 32'hFFFF_8001);
    do_load(32'h20, 3'b010, 1'b0, 0, 0, v);  chk("lhu", v, 32'h0000_8001);

    // Store and load requested together: store first, bubble, then load.
    rob_addr = 32'h200; rob_width = 3'b100; rob_data = 32'hDEAD_BEEF;
    lb_addr = 32'h200; lb_width = 3'b100; lb_sgn = 1'b0;
    rob_en = 1'b1; lb_en = 1'b1;
    cyc = 0; st_cyc = 0; ld_cyc = 0; nw = 0; v = '0;
    while (ld_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_wr) begin
        sh = rob_data >> (8 * nw);
        chk("prio_addr", mem_a, 32'h200 + 32'(nw));
        chk("prio_byte", 32'(mem_dout), 32'(sh[7:0]));
        nw++;
      end
      if (rob_done) begin
        if (st_cyc == 0) st_cyc = cyc;
        rob_en = 1'b0;
      end
      if (lb_done) begin ld_cyc = cyc; v = lb_data; end
    end
    lb_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sh = 32'hDEAD_BEEF >> (8 * k);
      ref_mem[10'h200 + 10'(k)] = sh[7:0];
    end
    chk("prio_store_done_cycle", st_cyc, 5);
    chk("prio_load_done_cycle", ld_cyc, 12);
    chk("prio_nbytes", nw, 4);
    chk("prio_load_data", v, 32'hDEAD_BEEF);
    chk("prio_model", v, exp_load(32'h200, 3'b100, 1'b0));
    @(negedge clk);

    do_load(32'h100, 3'b100, 1'b0, 0, 2, v);
    do_load(32'h100, 3'b100, 1'b0, 0, 0, v); chk("lw_after_flush", v, 32'h4433_2211);

    do_store(32'h180, 3'b010, 32'h0000_ABCD, 1);
    do_load(32'h180, 3'b010, 1'b1, 0, 0, v); chk("sh_flush_readback", v, 32'hFFFF_ABCD);

    do_load(32'h100, 3'b100, 1'b0, 1, 0, v); chk("lw_stall", v, 32'h4433_2211);

    do_load(32'hFFFF_FFFF, 3'b010, 1'b1, 0, 0, v); chk("lh_wrap", v, 32'hFFFF_9A7F);
    do_load(32'hFFFF_FFFF, 3'b010, 1'b0, 0, 0, v); chk("lhu_wrap", v, 32'h0000_9A7F);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [2:0] rw;
      ra = 32'h140 + $urandom_range(0, 32'hB0);
      case ($urandom_range(0, 3))
        0: rw = 3'd1;
        1: rw = 3'd2;
        2: rw = 3'd4;
        default: rw = 3'd0;
      endcase
      if ($urandom_range(0, 1) == 1) do_store(ra, rw, $urandom, 0);
      else do_load(ra, rw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, v);
    end

    // Asynchronous reset in the middle of a store.
    rob_addr = 32'h300; rob_width = 3'b100; rob_data = $urandom; rob_en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("store_active", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    rob_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h100, 3'b100, 1'b0, 0, 0, v); chk("lw_after_reset", v, 32'h4433_2211);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
